// File: rtl/mult_hilo_ctrl.sv
// Purpose: sequencer and HI/LO result store for the 16-bit signed multiplier.
// Latency: product captured into HI/LO LAT cycles after the start edge; done pulses the cycle after.
// Backpressure: no queueing; start/MT/MF while busy raise stall and the pipeline holds the request.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, op_a, op_b   multiply request (accepted in IDLE only) and signed operands
//   mul_x, mul_y        latched operands held on the external combinational multiplier
//   mul_z               signed 2*DATA_W product from the multiplier
//   busy, done          busy while settling; done is a one-cycle pulse after HI/LO capture
//   rd_req, rd_sel      MFHI/MFLO request; rd_sel picks HI(1)/LO(0) for reads and writes
//   rd_data             rd_sel ? hi : lo, straight from the registers
//   wr_en, wr_data      MTHI/MTLO write, honoured in IDLE only
//   stall               busy & (rd_req | wr_en | start)
module mult_hilo_ctrl #(
  parameter int DATA_W = 16,
  parameter int LAT    = 2   // settle cycles, 1..15 (cnt is 4 bits)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic [DATA_W-1:0]   mul_x,
  output logic [DATA_W-1:0]   mul_y,
  input  logic [2*DATA_W-1:0] mul_z,
  output logic                busy,
  output logic                done,
  input  logic                rd_req,
  input  logic                rd_sel,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                stall
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Counter starts at LAT-1 so that the capture edge is exactly LAT edges after the start edge.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                done_q, done_d;
  logic                accept;
  logic                capture;

  assign accept  = (state_q == IDLE) && start;
  assign capture = (state_q == SETTLE) && (cnt_q == 4'd0);

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= '0;
      lo_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Datapath next values and outputs.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = capture;

    // Operands only move on an accepted start, so the multiplier inputs are stable while settling.
    if (accept) begin
      x_d = op_a;
      y_d = op_b;
    end

    // MTHI/MTLO is honoured only in IDLE; while busy the stall keeps the instruction waiting.
    if ((state_q == IDLE) && wr_en) begin
      if (rd_sel) hi_d = wr_data;
      else        lo_d = wr_data;
    end

    // A capture always wins; it cannot coincide with a write since writes need IDLE.
    if (capture) begin
      hi_d = mul_z[2*DATA_W-1:DATA_W];
      lo_d = mul_z[DATA_W-1:0];
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = done_q;
    mul_x   = x_q;
    mul_y   = y_q;
    rd_data = rd_sel ? hi_q : lo_q;
    stall   = busy && (rd_req || wr_en || start);
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl: products queued at issue, monitor checks them on done.
module tb_mult_hilo_ctrl;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic [DW-1:0] mul_x, mul_y;
  logic [2*DW-1:0] mul_z;
  logic          busy, done;
  logic          rd_req = 1'b0, rd_sel = 1'b0;
  logic [DW-1:0] rd_data;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   model_hi = '0, model_lo = '0;

  mult_hilo_ctrl #(.DATA_W(DW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .wr_en(wr_en), .wr_data(wr_data), .stall(stall)
  );

  always #5 clk = ~clk;

  // Ideal signed product with plain integer arithmetic.
  function automatic logic [2*DW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  always_comb mul_z = ref_prod(mul_x, mul_y);

  task automatic check16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1, expected no pending product (t=%0t)", $time);
      end else begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        check16("done_result", rd_data, rd_sel ? e[2*DW-1:DW] : e[DW-1:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input logic sel, input string name);
    rd_sel = sel;
    #1;
    check16(name, rd_data, sel ? model_hi : model_lo);
  endtask

  task automatic check_hl(input string name, input logic [DW-1:0] hi_e, input logic [DW-1:0] lo_e);
    rd_sel = 1'b1;
    #1;
    check16({name, "_hi"}, rd_data, hi_e);
    rd_sel = 1'b0;
    #1;
    check16({name, "_lo"}, rd_data, lo_e);
  endtask

  // Start a multiply in the current (idle) cycle; the result is known up front.
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    check1("issue_idle", busy, 1'b0);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    p = ref_prod(a, b);
    exp_q.push_back(p);
    model_hi = p[2*DW-1:DW];
    model_lo = p[DW-1:0];
  endtask

  // MTHI/MTLO in idle, taking effect at the next edge.
  task automatic mt(input logic sel, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    rd_sel  = sel;
    wr_data = d;
    if (sel) model_hi = d;
    else     model_lo = d;
    tick();
    wr_en = 1'b0;
  endtask

  // mode 0: quiet, 1: MFHI held during settle, 2: MT write attempted during settle.
  // Returns at the negedge of the done cycle.
  task automatic mul_seq(input logic [DW-1:0] a, input logic [DW-1:0] b, input int mode);
    issue(a, b);
    tick();
    start   = 1'b0;
    op_a    = 16'($urandom);
    op_b    = 16'($urandom);
    wr_en   = (mode == 2);
    wr_data = 16'($urandom);
    rd_req  = (mode == 1);
    if (mode == 1) rd_sel = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check1("settle_busy", busy, 1'b1);
      check1("settle_done", done, 1'b0);
      check1("settle_stall", stall, mode != 0);
      check16("settle_mul_x", mul_x, a);
      check16("settle_mul_y", mul_y, b);
      tick();
    end
    wr_en = 1'b0;
    @(negedge clk);
    check1("done_pulse", done, 1'b1);
    check1("done_busy", busy, 1'b0);
    check1("done_stall", stall, 1'b0);
    if (mode == 1) check16("hazard_new_hi", rd_data, model_hi);
    rd_req = 1'b0;
  endtask

  // Async reset pulse from mid-cycle; state must clear before the next edge.
  task automatic reset_mid(input string name);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    start = 1'b0;
    wr_en = 1'b0;
    #1;
    check1({name, "_busy"}, busy, 1'b0);
    check1({name, "_done"}, done, 1'b0);
    check16({name, "_mul_x"}, mul_x, 16'h0000);
    check16({name, "_mul_y"}, mul_y, 16'h0000);
    check_hl(name, 16'h0000, 16'h0000);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Power-up reset.
    repeat (2) @(posedge clk);
    #1;
    check1("por_busy", busy, 1'b0);
    check1("por_done", done, 1'b0);
    check_hl("por", 16'h0000, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Mid-cycle reset with nonzero state and a multiply in flight.
    mt(1'b0, 16'hAAAA);
    mt(1'b1, 16'h5555);
    issue(16'h0101, 16'h0202);
    tick();
    start = 1'b0;
    reset_mid("rst_mid");

    // Basic: 3 * -5.
    mul_seq(16'h0003, 16'hFFFB, 0);
    check_hl("basic", 16'hFFFF, 16'hFFF1);

    // Extremes and back-to-back start in the done cycle.
    mul_seq(16'h8000, 16'h8000, 0);
    check_hl("minmin", 16'h4000, 16'h0000);
    mul_seq(16'h7FFF, 16'h0002, 0);
    check_hl("b2b", 16'h0000, 16'hFFFE);

    // Hazards: MFHI during settle, then MT during settle.
    mul_seq(16'h1234, 16'h0100, 1);
    check_hl("hazard_rd", 16'h0012, 16'h3400);
    mul_seq(16'hFFFF, 16'hFFFF, 2);
    check_hl("hazard_wr", 16'h0000, 16'h0001);

    // MTLO in idle, then start together with MTHI.
    tick();
    mt(1'b0, 16'h1234);
    check_hl("mtlo", 16'h0000, 16'h1234);
    wr_en   = 1'b1;
    rd_sel  = 1'b1;
    wr_data = 16'hBEEF;
    mul_seq(16'h0002, 16'h0002, 0);
    check_hl("mthi_start", 16'h0000, 16'h0004);

    // Reset during settle: no done, cleared state, next multiply normal.
    tick();
    issue(16'h1111, 16'h2222);
    tick();
    start = 1'b0;
    reset_mid("rst_settle");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("post_rst_no_done", done, 1'b0);
    end
    tick();
    mul_seq(16'hFFFE, 16'h0003, 0);
    check_hl("post_rst_mul", 16'hFFFF, 16'hFFFA);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      logic [DW-1:0] a, b;
      int gap;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFFFF;
      rd_sel = 1'($urandom_range(0, 1));
      mul_seq(a, b, int'($urandom_range(0, 2)));
      check_rd(1'b0, "rand_lo");
      check_rd(1'b1, "rand_hi");
      if ($urandom_range(0, 2) == 0) begin
        logic s;
        s = 1'($urandom_range(0, 1));
        mt(s, 16'($urandom));
        check_rd(s, "rand_mt");
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end

    repeat (3) tick();
    check16("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
